tdm_demux: RTL



---
 rtl/tdm_pkg.sv | 13 +
 rtl/tdm_frame_reg.sv | 36 +++
 rtl/tdm_demux.sv | 87 ++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared defaults and slot-width helper for the tdm demux slice
package tdm_pkg;

   localparam int TDM_LANES_DEF = 4;
   localparam int TDM_W_DEF     = 1;
   localparam int ERR_CNT_W     = 8;

   // Slot index width for a lane count; never narrower than one bit.
   function automatic int tdm_selw(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/tdm_frame_reg.sv
// rtl/tdm_frame_reg.sv - output frame holding register with valid/ready EMPTY/FULL control
module tdm_frame_reg
   import tdm_pkg::*;
#(
   parameter int DW = TDM_LANES_DEF * TDM_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data
);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0] state;

   assign out_valid = (state == FULL);

   // A load wins over a drain so a frame completing on the drain edge is not lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= EMPTY;
         out_data <= '0;
      end else if (load) begin
         state    <= FULL;
         out_data <= load_data;
      end else if (out_valid && out_ready) begin
         state    <= EMPTY;
      end
   end

endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM slot stream to parallel frame demux; optional err_cnt under TDM_DEMUX_ERR_CNT_EN
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int W     = TDM_W_DEF,
   parameter int LANES = TDM_LANES_DEF,
   parameter int SELW  = tdm_selw(LANES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [W-1:0]         in_data,
   input  logic                 in_sof,
   output logic                 in_ready,
   output logic [SELW-1:0]      slot,
   output logic                 out_valid,
   output logic [LANES*W-1:0]   out_data,
   input  logic                 out_ready,
   output logic                 err_sync
`ifdef TDM_DEMUX_ERR_CNT_EN
   ,
   output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

   localparam logic [SELW-1:0] LAST = SELW'(LANES - 1);

   logic [LANES*W-1:0] asm_q;
   logic [LANES*W-1:0] frame_next;
   logic               accept;
   logic               resync;
   logic               complete;

   // Only the closing beat can stall: earlier beats land in the assembly lanes, not the output.
   assign in_ready = !((slot == LAST) && out_valid && !out_ready);
   assign accept   = in_valid && in_ready;
   assign resync   = accept && in_sof && (slot != '0);
   assign complete = accept && !resync && (slot == LAST);

   // Completed frame is the assembled lanes with the closing beat spliced into the top lane.
   always_comb begin
      frame_next = asm_q;
      frame_next[(LANES-1)*W +: W] = in_data;
   end

   // Slot counter, assembly lanes and the sync check; a misplaced sof restarts at lane 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot     <= '0;
         asm_q    <= '0;
         err_sync <= 1'b0;
      end else begin
         err_sync <= resync;
         if (resync) begin
            asm_q <= {{((LANES-1)*W){1'b0}}, in_data};
            slot  <= SELW'(1);
         end else if (accept) begin
            asm_q[slot*W +: W] <= in_data;
            slot <= (slot == LAST) ? '0 : slot + SELW'(1);
         end
      end
   end

   tdm_frame_reg #(
      .DW (LANES*W)
   ) u_frame_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (complete),
      .load_data (frame_next),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

`ifdef TDM_DEMUX_ERR_CNT_EN
   // Saturating count of sync errors, stepped by the registered pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (err_sync && (err_cnt != '1)) begin
         err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
   end
`endif

endmodule
